module2_coarse_cfo_cmul_pipe: RTL and testbench
===============================================

Name: module2_coarse_cfo_cmul_pipe

Overview:
- Parametrised, pipelined signed complex multiplier with valid/ready flow control, for the coarse CFO delay-correlator datapath.
- Computes a*b or a*conj(b), selectable per transaction.
- Applies a rounding right-shift and saturates the result to the output width.
- Reports saturation per sample and through a sticky flag; replaces the scalar 16s x 16s -> 32 combinational multipliers in this datapath.

Parameters:
DIN_W, 16, width of each signed input component (a_re, a_im, b_re, b_im); legal 2..24
OUT_W, 16, width of each signed output component; legal 2..2*DIN_W+1
SHIFT, 15, arithmetic right shift applied to the full-precision result; legal 0..2*DIN_W
NUM_STAGE, 3, total latency in cycles from input accept to out_valid; legal >= 1

Ports:
ap_clk  in  1  clock; all logic on the rising edge
ap_rst  in  1  synchronous, active-high reset
in_valid  in  1  input transaction valid
in_ready  out  1  block can accept an input this cycle
a_re, a_im  in  DIN_W each  operand a, signed
b_re, b_im  in  DIN_W each  operand b, signed
conj_b  in  1  1: compute a*conj(b); 0: compute a*b; sampled with the operands
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
y_re, y_im  out  OUT_W each  result, signed
out_sat  out  1  this result saturated in y_re or y_im
sat_sticky  out  1  a saturated result has been accepted since the last clear
sat_clr  in  1  clears sat_sticky

Behaviour:
- Reset (ap_rst=1 at a clock edge): all stage-valid bits, out_valid, out_sat and sat_sticky go to 0; y_re and y_im go to 0. Any in-flight data is discarded. in_ready is 1 in the cycle after reset deasserts.
- Advance enable: en = out_ready | ~out_valid.
  - in_ready = en, driven combinationally.
  - An input is accepted when in_valid & in_ready.
  - When en=0 every stage holds, including valid bits and data.
  - When en=1 every stage shifts by one; an empty slot (valid=0) enters stage 1 if no input is accepted.
  - Bubbles are not compressed; this is a global-stall pipeline.
- Latency: exactly NUM_STAGE enabled cycles from accept to out_valid=1. Full throughput of one sample per cycle while out_ready=1. Order is preserved.
- Arithmetic, with FULL_W = 2*DIN_W+1 and all products full precision:
  - conj_b=0: re = ar*br - ai*bi; im = ar*bi + ai*br.
  - conj_b=1: re = ar*br + ai*bi; im = ai*br - ar*bi.
- Rounding:
  - If SHIFT>0: r = (v + 2^(SHIFT-1)) >>> SHIFT, i.e. round half toward +inf, computed in FULL_W+1 bits with no intermediate overflow.
  - If SHIFT=0: r = v.
- Saturation:
  - r > 2^(OUT_W-1)-1 gives 2^(OUT_W-1)-1; r < -2^(OUT_W-1) gives -2^(OUT_W-1).
  - out_sat = sat_re | sat_im, carried in step with the data.
- Stage mapping for NUM_STAGE>=3:
  - Stage 1 registers the four products and conj_b.
  - Stage 2 registers the sums with the rounding constant added.
  - Stage 3 registers the shift/saturate result.
  - Stages 4..NUM_STAGE are pure delay stages carrying valid, data and sat.
- NUM_STAGE=2 merges stages 2 and 3. NUM_STAGE=1 merges all three behind a single register. Results are bit-identical for every NUM_STAGE.
- y_re, y_im and out_sat hold their last values while out_valid=0 or while stalled.
- sat_sticky:
  - Set on the cycle after out_valid & out_ready & out_sat.
  - Cleared on the cycle after sat_clr=1.
  - If set and clear occur in the same cycle, set wins.
- Simultaneous accept and emit in the same cycle is normal operation; occupancy stays constant.
- A reset asserted mid-stall overrides en.

Test Plan:
- Defaults, conj_b=0, a=(16384,0), b=(16384,0) -> y=(8192,0), out_valid exactly 3 cycles after accept, out_sat=0.
- Rounding, conj_b=0: a=(1,0), b=(16384,0) -> y_re=1. a=(-1,0), b=(16384,0) -> y_re=0. a=(3,0), b=(-16384,0) -> y_re=-1.
- Saturation and conjugate: conj_b=1, a=b=(-32768,-32768) -> y=(32767,0), out_sat=1, sat_sticky=1 after accept. Then assert sat_clr together with another saturating accept -> sat_sticky stays 1. Assert sat_clr alone -> sat_sticky becomes 0.
- Backpressure with random in_valid/out_ready over 2000 random operands and random conj_b -> the output stream matches the reference model in order, with no loss or duplication. in_ready=0 exactly when out_valid=1 and out_ready=0.
- Assert ap_rst for one cycle with 3 samples in flight and out_ready=0 -> next cycle out_valid=0, y=(0,0), sat_sticky=0. The first post-reset input emerges after exactly NUM_STAGE cycles.
- Parameter sweep NUM_STAGE in {1,2,5}, plus DIN_W=12, OUT_W=25, SHIFT=0 -> results bit-identical to the model, latency equals NUM_STAGE. a=b=(-2048,-2048) with conj_b=1 gives y_re=8388608 with no saturation.

Source files
------------

// File: rtl/module2_coarse_cfo_cmul_pipe.sv
// Pipelined signed complex multiplier (a*b or a*conj(b)) with
// rounding shift, saturation and a global-stall valid/ready pipeline.
module module2_coarse_cfo_cmul_pipe #(
  parameter int DIN_W     = 16,
  parameter int OUT_W     = 16,
  parameter int SHIFT     = 15,
  parameter int NUM_STAGE = 3
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DIN_W-1:0] a_re,
  input  logic signed [DIN_W-1:0] a_im,
  input  logic signed [DIN_W-1:0] b_re,
  input  logic signed [DIN_W-1:0] b_im,
  input  logic                    conj_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] y_re,
  output logic signed [OUT_W-1:0] y_im,
  output logic                    out_sat,
  output logic                    sat_sticky,
  input  logic                    sat_clr
);

  localparam int FULL_W = 2*DIN_W+1;
  localparam int SUM_W  = FULL_W+1;
  localparam int PRD_W  = 2*DIN_W;
  localparam int NRES   = (NUM_STAGE >= 3) ? NUM_STAGE-2 : 1;
  localparam int NPRE   = NUM_STAGE - NRES;

  localparam logic [SUM_W-1:0] ONE = SUM_W'(1);
  localparam logic signed [SUM_W-1:0] RND =
    signed'((ONE << SHIFT) >> 1);
  localparam logic signed [SUM_W-1:0] MAXV =
    signed'((ONE << (OUT_W-1)) - ONE);
  localparam logic signed [SUM_W-1:0] MINV =
    signed'(~((ONE << (OUT_W-1)) - ONE));

  typedef struct packed {
    logic             sat;
    logic [OUT_W-1:0] re;
    logic [OUT_W-1:0] im;
  } res_t;

  logic                 en;
  logic                 acc;
  logic [NUM_STAGE-1:0] vld;
  logic [NUM_STAGE:0]   vld_n;

  assign en        = out_ready | ~out_valid;
  assign in_ready  = en;
  assign acc       = in_valid & en;
  assign vld_n     = {vld, acc};
  assign out_valid = vld[NUM_STAGE-1];

  always_ff @(posedge ap_clk)
    if (ap_rst)  vld <= '0;
    else if (en) vld <= vld_n[NUM_STAGE-1:0];

  logic signed [PRD_W-1:0] m_rr, m_ii, m_ri, m_ir;
  logic signed [PRD_W-1:0] p_rr, p_ii, p_ri, p_ir;
  logic                    p_conj;

  assign m_rr = a_re * b_re;
  assign m_ii = a_im * b_im;
  assign m_ri = a_re * b_im;
  assign m_ir = a_im * b_re;

  generate
    if (NPRE >= 1) begin : g_s1
      always_ff @(posedge ap_clk)
        if (acc) begin
          p_rr   <= m_rr;
          p_ii   <= m_ii;
          p_ri   <= m_ri;
          p_ir   <= m_ir;
          p_conj <= conj_b;
        end
    end else begin : g_s1c
      assign p_rr   = m_rr;
      assign p_ii   = m_ii;
      assign p_ri   = m_ri;
      assign p_ir   = m_ir;
      assign p_conj = conj_b;
    end
  endgenerate

  // one extra bit so the rounding add can never wrap
  logic signed [SUM_W-1:0] e_rr, e_ii, e_ri, e_ir;
  logic signed [SUM_W-1:0] s_re, s_im;
  logic signed [SUM_W-1:0] q_re, q_im;

  always_comb begin
    e_rr = SUM_W'(p_rr);
    e_ii = SUM_W'(p_ii);
    e_ri = SUM_W'(p_ri);
    e_ir = SUM_W'(p_ir);
    if (p_conj) begin
      s_re = e_rr + e_ii + RND;
      s_im = e_ir - e_ri + RND;
    end else begin
      s_re = e_rr - e_ii + RND;
      s_im = e_ri + e_ir + RND;
    end
  end

  generate
    if (NPRE >= 2) begin : g_s2
      always_ff @(posedge ap_clk)
        if (en & vld_n[1]) begin
          q_re <= s_re;
          q_im <= s_im;
        end
    end else begin : g_s2c
      assign q_re = s_re;
      assign q_im = s_im;
    end
  endgenerate

  function automatic logic [OUT_W:0] shsat(
    input logic signed [SUM_W-1:0] v
  );
    logic signed [SUM_W-1:0] s;
    s = v >>> SHIFT;
    if (s > MAXV)      shsat = {1'b1, MAXV[OUT_W-1:0]};
    else if (s < MINV) shsat = {1'b1, MINV[OUT_W-1:0]};
    else               shsat = {1'b0, s[OUT_W-1:0]};
  endfunction

  logic [OUT_W:0] r_re, r_im;
  res_t           res_c;

  always_comb begin
    r_re      = shsat(q_re);
    r_im      = shsat(q_im);
    res_c.sat = r_re[OUT_W] | r_im[OUT_W];
    res_c.re  = r_re[OUT_W-1:0];
    res_c.im  = r_im[OUT_W-1:0];
  end

  // data only loads behind a valid, so outputs hold through bubbles
  res_t res_q [NRES];

  generate
    for (genvar i = 0; i < NRES; i++) begin : g_res
      if (i == 0) begin : g_h
        always_ff @(posedge ap_clk)
          if (ap_rst)                 res_q[i] <= '0;
          else if (en & vld_n[NPRE]) res_q[i] <= res_c;
      end else begin : g_d
        always_ff @(posedge ap_clk)
          if (ap_rst)                   res_q[i] <= '0;
          else if (en & vld_n[NPRE+i]) res_q[i] <= res_q[i-1];
      end
    end
  endgenerate

  assign y_re    = res_q[NRES-1].re;
  assign y_im    = res_q[NRES-1].im;
  assign out_sat = res_q[NRES-1].sat;

  always_ff @(posedge ap_clk)
    if (ap_rst)                             sat_sticky <= 1'b0;
    else if (out_valid & out_ready & out_sat) sat_sticky <= 1'b1;
    else if (sat_clr)                       sat_sticky <= 1'b0;

endmodule

// File: tb/tb_module2_coarse_cfo_cmul_pipe.sv
// Scoreboard bench for the complex multiplier pipeline, including
// a latency/parameter sweep over several instances.
module tb_module2_coarse_cfo_cmul_pipe;

  typedef struct {
    longint re;
    longint im;
    bit     sat;
  } exp_t;

  logic clk = 1'b0;
  logic ap_rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic conj_b = 1'b0;
  logic sat_clr = 1'b0;
  logic signed [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic signed [11:0] c_re = '0, c_im = '0, d_re = '0, d_im = '0;

  logic in_ready, out_valid, out_sat, sat_sticky;
  logic signed [15:0] y_re, y_im;

  logic ir1, ov1, os1, st1, ir2, ov2, os2, st2;
  logic ir5, ov5, os5, st5, irc, ovc, osc, stc;
  logic signed [15:0] y1r, y1i, y2r, y2i, y5r, y5i;
  logic signed [24:0] ycr, yci;

  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  exp_t q[$];
  exp_t mon_e;

  logic   ov[4];
  logic   os[4];
  longint yr[4];
  longint yi[4];
  int     lat[4] = '{1, 2, 5, 3};

  always #5 clk = ~clk;

  module2_coarse_cfo_cmul_pipe u0 (
    .ap_clk(clk), .ap_rst(ap_rst), .in_valid(in_valid),
    .in_ready(in_ready), .a_re(a_re), .a_im(a_im), .b_re(b_re),
    .b_im(b_im), .conj_b(conj_b), .out_valid(out_valid),
    .out_ready(out_ready), .y_re(y_re), .y_im(y_im),
    .out_sat(out_sat), .sat_sticky(sat_sticky), .sat_clr(sat_clr));

  module2_coarse_cfo_cmul_pipe #(.NUM_STAGE(1)) u1 (
    .ap_clk(clk), .ap_rst(ap_rst), .in_valid(in_valid),
    .in_ready(ir1), .a_re(a_re), .a_im(a_im), .b_re(b_re),
    .b_im(b_im), .conj_b(conj_b), .out_valid(ov1),
    .out_ready(out_ready), .y_re(y1r), .y_im(y1i),
    .out_sat(os1), .sat_sticky(st1), .sat_clr(sat_clr));

  module2_coarse_cfo_cmul_pipe #(.NUM_STAGE(2)) u2 (
    .ap_clk(clk), .ap_rst(ap_rst), .in_valid(in_valid),
    .in_ready(ir2), .a_re(a_re), .a_im(a_im), .b_re(b_re),
    .b_im(b_im), .conj_b(conj_b), .out_valid(ov2),
    .out_ready(out_ready), .y_re(y2r), .y_im(y2i),
    .out_sat(os2), .sat_sticky(st2), .sat_clr(sat_clr));

  module2_coarse_cfo_cmul_pipe #(.NUM_STAGE(5)) u5 (
    .ap_clk(clk), .ap_rst(ap_rst), .in_valid(in_valid),
    .in_ready(ir5), .a_re(a_re), .a_im(a_im), .b_re(b_re),
    .b_im(b_im), .conj_b(conj_b), .out_valid(ov5),
    .out_ready(out_ready), .y_re(y5r), .y_im(y5i),
    .out_sat(os5), .sat_sticky(st5), .sat_clr(sat_clr));

  module2_coarse_cfo_cmul_pipe #(
    .DIN_W(12), .OUT_W(25), .SHIFT(0), .NUM_STAGE(3)
  ) uc (
    .ap_clk(clk), .ap_rst(ap_rst), .in_valid(in_valid),
    .in_ready(irc), .a_re(c_re), .a_im(c_im), .b_re(d_re),
    .b_im(d_im), .conj_b(conj_b), .out_valid(ovc),
    .out_ready(out_ready), .y_re(ycr), .y_im(yci),
    .out_sat(osc), .sat_sticky(stc), .sat_clr(sat_clr));

  always_comb begin
    ov[0] = ov1; os[0] = os1; yr[0] = longint'(y1r); yi[0] = longint'(y1i);
    ov[1] = ov2; os[1] = os2; yr[1] = longint'(y2r); yi[1] = longint'(y2i);
    ov[2] = ov5; os[2] = os5; yr[2] = longint'(y5r); yi[2] = longint'(y5i);
    ov[3] = ovc; os[3] = osc; yr[3] = longint'(ycr); yi[3] = longint'(yci);
  end

  function automatic exp_t model(
    input longint ar, input longint ai,
    input longint br, input longint bi,
    input bit cj, input int ow, input int sh
  );
    exp_t   e;
    longint v[2];
    longint mx, mn;
    bit     s;
    if (!cj) begin
      v[0] = ar*br - ai*bi;
      v[1] = ar*bi + ai*br;
    end else begin
      v[0] = ar*br + ai*bi;
      v[1] = ai*br - ar*bi;
    end
    mx = (longint'(1) <<< (ow-1)) - 1;
    mn = -mx - 1;
    s = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (sh > 0) v[i] = (v[i] + (longint'(1) <<< (sh-1))) >>> sh;
      if (v[i] > mx) begin v[i] = mx; s = 1'b1; end
      if (v[i] < mn) begin v[i] = mn; s = 1'b1; end
    end
    e.re = v[0];
    e.im = v[1];
    e.sat = s;
    return e;
  endfunction

  function automatic logic signed [15:0] rnd16();
    logic signed [15:0] r;
    r = 16'($urandom);
    if ($urandom_range(0, 7) == 0) r = 16'sh8000;
    if ($urandom_range(0, 7) == 0) r = 16'sh7fff;
    return r;
  endfunction

  // scoreboard for the default instance
  always @(negedge clk) begin
    if (mon_en && !ap_rst) begin
      if (in_valid && in_ready)
        q.push_back(model(longint'(a_re), longint'(a_im),
                          longint'(b_re), longint'(b_im),
                          conj_b, 16, 15));
      n_chk++;
      if (in_ready !== ~(out_valid & ~out_ready)) begin
        n_fail++;
        $display("FAIL in_ready_rule: got %0b with ov=%0b or=%0b",
                 in_ready, out_valid, out_ready);
      end
      if (out_valid && out_ready) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra_output: got y=(%0d,%0d) want none",
                   y_re, y_im);
        end else begin
          mon_e = q.pop_front();
          if (longint'(y_re) !== mon_e.re ||
              longint'(y_im) !== mon_e.im || out_sat !== mon_e.sat) begin
            n_fail++;
            $display("FAIL sb_data: got (%0d,%0d,%0b) want (%0d,%0d,%0b)",
                     y_re, y_im, out_sat, mon_e.re, mon_e.im, mon_e.sat);
          end
        end
      end
    end
  end

  task automatic drive(input bit v, input logic signed [15:0] ar,
                       input logic signed [15:0] ai,
                       input logic signed [15:0] br,
                       input logic signed [15:0] bi, input bit cj);
    in_valid = v;
    a_re = ar; a_im = ai; b_re = br; b_im = bi;
    conj_b = cj;
  endtask

  task automatic pulse_reset();
    mon_en = 1'b0;
    q.delete();
    @(posedge clk); #1;
    in_valid = 1'b0;
    ap_rst = 1'b1;
    @(posedge clk); #1;
    ap_rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 ap_rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0 || y_re !== 16'sd0 || y_im !== 16'sd0 ||
        out_sat !== 1'b0 || sat_sticky !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got ov=%0b y=(%0d,%0d) s=%0b st=%0b ir=%0b want 0,(0,0),0,0,1",
               out_valid, y_re, y_im, out_sat, sat_sticky, in_ready);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      drive(k == 0, 16384, 0, 16384, 0, 1'b0);
      @(negedge clk);
      n_chk++;
      if (out_valid !== (k == 3)) begin
        n_fail++;
        $display("FAIL basic_latency k=%0d: got ov=%0b want %0b",
                 k, out_valid, k == 3);
      end
      if (k == 3) begin
        n_chk++;
        if (y_re !== 16'sd8192 || y_im !== 16'sd0 || out_sat !== 1'b0) begin
          n_fail++;
          $display("FAIL basic_value: got (%0d,%0d,%0b) want (8192,0,0)",
                   y_re, y_im, out_sat);
        end
      end
    end
  endtask

  task automatic test_rounding();
    logic signed [15:0] ar[3] = '{16'sd1, -16'sd1, 16'sd3};
    logic signed [15:0] br[3] = '{16'sd16384, 16'sd16384, -16'sd16384};
    logic signed [15:0] ex[3] = '{16'sd1, 16'sd0, -16'sd1};
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (k < 3) drive(1'b1, ar[k], 0, br[k], 0, 1'b0);
      else       drive(1'b0, 0, 0, 0, 0, 1'b0);
      @(negedge clk);
      if (k >= 3) begin
        n_chk++;
        if (out_valid !== 1'b1 || y_re !== ex[k-3]) begin
          n_fail++;
          $display("FAIL rounding_%0d: got ov=%0b y_re=%0d want 1,%0d",
                   k-3, out_valid, y_re, ex[k-3]);
        end
      end
    end
  endtask

  task automatic test_sat_sticky();
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      drive(k == 0 || k == 5, -32768, -32768, -32768, -32768, 1'b1);
      sat_clr = (k >= 5 && k <= 8) || k == 10;
      @(negedge clk);
      if (k == 3) begin
        n_chk++;
        if (y_re !== 16'sd32767 || y_im !== 16'sd0 || out_sat !== 1'b1) begin
          n_fail++;
          $display("FAIL sat_value: got (%0d,%0d,%0b) want (32767,0,1)",
                   y_re, y_im, out_sat);
        end
      end
      if (k == 4 || k == 6 || k == 9 || k == 10 || k == 11) begin
        n_chk++;
        if (sat_sticky !== (k != 6 && k != 11)) begin
          n_fail++;
          $display("FAIL sticky_k%0d: got %0b want %0b",
                   k, sat_sticky, k != 6 && k != 11);
        end
      end
    end
    sat_clr = 1'b0;
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int cyc = 0;
    while (sent < 2000 && cyc < 20000) begin
      @(posedge clk); #1;
      drive($urandom_range(0, 9) < 7, rnd16(), rnd16(), rnd16(),
            rnd16(), 1'($urandom));
      out_ready = $urandom_range(0, 9) < 6;
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    n_chk++;
    if (sent < 2000) begin
      n_fail++;
      $display("FAIL bp_budget: got %0d accepts want 2000", sent);
    end
    cyc = 0;
    while ((q.size() != 0 || out_valid) && cyc < 50) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      cyc++;
    end
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_drain: got %0d pending want 0", q.size());
    end
  endtask

  task automatic test_reset_inflight();
    for (int k = 0; k < 11; k++) begin
      @(posedge clk); #1;
      out_ready = (k < 5);
      if (k == 0)
        drive(1'b1, -32768, -32768, -32768, -32768, 1'b1);
      else
        drive(k >= 5 && k <= 7, rnd16(), rnd16(), rnd16(), rnd16(), 1'b0);
      @(negedge clk);
    end
    n_chk++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || sat_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_state: got ov=%0b ir=%0b st=%0b want 1,0,1",
               out_valid, in_ready, sat_sticky);
    end
    pulse_reset();
    out_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0 || y_re !== 16'sd0 || y_im !== 16'sd0 ||
        sat_sticky !== 1'b0 || out_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_flight: got ov=%0b y=(%0d,%0d) st=%0b s=%0b want 0,(0,0),0,0",
               out_valid, y_re, y_im, sat_sticky, out_sat);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      drive(k == 0, 16384, -16384, 8192, 4096, 1'b0);
      @(negedge clk);
      n_chk++;
      if (out_valid !== (k == 3)) begin
        n_fail++;
        $display("FAIL rst_latency k=%0d: got ov=%0b want %0b",
                 k, out_valid, k == 3);
      end
    end
  endtask

  task automatic test_sweep();
    localparam int N = 40;
    bit   vin[N];
    exp_t e16[N];
    exp_t e12[N];
    exp_t ee;
    int   src;
    bit   ev;
    pulse_reset();
    out_ready = 1'b1;
    for (int c = 0; c < N + 7; c++) begin
      @(posedge clk); #1;
      if (c < N) begin
        vin[c] = (c == 0) || ($urandom_range(0, 9) < 8);
        drive(vin[c], rnd16(), rnd16(), rnd16(), rnd16(),
              (c == 0) ? 1'b1 : 1'($urandom));
        if (c == 0) begin
          c_re = -12'sd2048; c_im = -12'sd2048;
          d_re = -12'sd2048; d_im = -12'sd2048;
        end else begin
          c_re = 12'($urandom); c_im = 12'($urandom);
          d_re = 12'($urandom); d_im = 12'($urandom);
          if ($urandom_range(0, 5) == 0) c_re = -12'sd2048;
        end
        e16[c] = model(longint'(a_re), longint'(a_im), longint'(b_re),
                       longint'(b_im), conj_b, 16, 15);
        e12[c] = model(longint'(c_re), longint'(c_im), longint'(d_re),
                       longint'(d_im), conj_b, 25, 0);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        src = c - lat[k];
        ev = (src >= 0 && src < N) ? vin[src] : 1'b0;
        n_chk++;
        if (ov[k] !== ev) begin
          n_fail++;
          $display("FAIL sweep_valid i%0d c%0d: got %0b want %0b",
                   k, c, ov[k], ev);
        end else if (ev) begin
          ee = (k == 3) ? e12[src] : e16[src];
          n_chk++;
          if (yr[k] !== ee.re || yi[k] !== ee.im || os[k] !== ee.sat) begin
            n_fail++;
            $display("FAIL sweep_data i%0d c%0d: got (%0d,%0d,%0b) want (%0d,%0d,%0b)",
                     k, c, yr[k], yi[k], os[k], ee.re, ee.im, ee.sat);
          end
        end
      end
      if (c == 3) begin
        n_chk++;
        if (yr[3] !== 64'sd8388608 || os[3] !== 1'b0) begin
          n_fail++;
          $display("FAIL wide_corner: got (%0d,%0b) want (8388608,0)",
                   yr[3], os[3]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_sat_sticky();
    test_backpressure();
    test_reset_inflight();
    test_sweep();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
